timer_intr_ctrl: RTL and testbench
==================================

# timer_intr_ctrl

Memory-mapped machine timer and external-interrupt front end that drives the 32-bit `interrupt` vector consumed by the CSR register file. It sits on the data-memory bus, alongside data memory, in the memory stage. It keeps a 64-bit free-running `mtime` with a programmable prescaler and compares it against `mtimecmp` to raise the timer request (bit 7). It also synchronises an asynchronous external line and latches its rising edge as the external request (bit 11).

## Interface
Parameters:
- `BASE_ADDR`, default 32'h8000_0000: register window base; a bus access hits when `addr[31:8] == BASE_ADDR[31:8]`.
- `PRESCALE`, default 4: core cycles per `mtime` tick; legal range 1..256.

Ports:
- `clk`  in  1  single clock for all state.
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset (fixed).
- `addr`  in  32  byte address from ALU result.
- `wdata`  in  32  store data.
- `wr_en`  in  1  store strobe, qualified by address hit.
- `rd_en`  in  1  load strobe, qualified by address hit.
- `ext_irq_i`  in  1  asynchronous external interrupt line, active-high.
- `rdata`  out  32  load data, combinational.
- `interrupt`  out  32  to CSR file; bit 7 = timer request, bit 11 = external request, all other bits 0.

## Operation
Register map (offset = `addr[7:0]`, word aligned; unmapped offsets read 0 and ignore writes):
- 0x00 MTIME_LO: `mtime[31:0]`, read/write.
- 0x04 MTIME_HI: read returns `hi_shadow`; write sets `mtime[63:32]`.
- 0x08 MTIMECMP_LO: `mtimecmp[31:0]`, read/write.
- 0x0C MTIMECMP_HI: `mtimecmp[63:32]`, read/write.
- 0x10 CTRL: bit0 `cnt_en`, bit1 `tmr_ie`, bit2 `ext_ie`; other bits read 0.
- 0x14 STATUS: bit0 `ext_pend` (write 1 clears), bit1 `tmr_irq` (read-only), bit2 raw synchronised `ext_irq`.

Prescaler:
- `pcnt` counts 0..PRESCALE-1 while `cnt_en`=1.
- When `pcnt`==PRESCALE-1, `pcnt` goes to 0 and `mtime` increments by 1. With PRESCALE=1 the increment happens every cycle.
- `cnt_en`=0 freezes both `pcnt` and `mtime`.
- `mtime` is 64-bit unsigned and wraps 64'hFFFF_FFFF_FFFF_FFFF to 0.

Writes:
- A write to MTIME_LO or MTIME_HI loads that half, suppresses the increment in that cycle, and clears `pcnt`.

Read snapshot:
- A read of MTIME_LO (`rd_en` with hit) captures `mtime[63:32]` into `hi_shadow` at the clock edge.
- A subsequent MTIME_HI read therefore returns the high word coherent with the low word already read.

Timer request:
- `tmr_irq` <= `tmr_ie` && (`mtime` >= `mtimecmp`), 64-bit unsigned compare on registered values.
- Level output; it clears only by raising `mtimecmp`, clearing `tmr_ie`, or `mtime` wrapping.

External request:
- `ext_irq_i` passes through a 2-flop synchroniser (`s1`, `s2`) and an edge register `s3`.
- Rise = `s2` & ~`s3`.
- Rise with `ext_ie`=1 sets `ext_pend`.
- Writing STATUS with bit0=1 clears `ext_pend`.
- Set and clear in the same cycle: set wins.
- A level held high does not re-set after a clear; a new rising edge is needed.

Outputs:
- `interrupt[7]` = `tmr_irq`.
- `interrupt[11]` = `ext_pend`.
- Both come straight from flops, with no combinational path from the bus.

## Timing
Reset values (applied on the first clock edge with `reset`=1):
- `mtime` 0, `pcnt` 0, `mtimecmp` all ones, CTRL 0, `ext_pend` 0, `tmr_irq` 0.
- `hi_shadow` 0, `s1`/`s2`/`s3` 0, so `interrupt` = 0.

Reset asserted mid-count or with a request pending:
- All state returns to reset values at that edge.
- `interrupt` is 0 in the following cycle.

Latencies:
- Writes are visible to reads the cycle after the write edge.
- `rdata` reflects current register state in the same cycle as `rd_en`.
- Timer: `tmr_irq` rises 1 cycle after the edge on which `mtime` becomes >= `mtimecmp`.
- Timer: `tmr_irq` rises 1 cycle after a CTRL or MTIMECMP write that makes the condition true.
- External: with `ext_irq_i` rising before edge E0, `interrupt[11]` is high after edge E3, a 3-cycle latency.
- `wr_en` and `rd_en` together on the same address: the read returns the pre-write value.

## Test plan
- Reset → `interrupt`=0, MTIMECMP_LO and MTIMECMP_HI read 32'hFFFF_FFFF, MTIME reads 0.
- PRESCALE=4; write CTRL=1, then wait 40 cycles → MTIME_LO reads 10 (±1 for write alignment); CTRL=0 → value holds constant.
- MTIMECMP_HI=0, MTIMECMP_LO=5, CTRL=3 → `interrupt[7]`=1 exactly 1 cycle after `mtime` reaches 5; then MTIMECMP_LO=100 → 0 next cycle.
- MTIME_HI=0, MTIME_LO=32'hFFFF_FFFF, PRESCALE=1, CTRL=1 → after 1 tick MTIME_LO=0 and MTIME_HI read after LO = 1. Also check all-ones 64-bit wraps to 0.
- CTRL=4, pulse `ext_irq_i` high 5 cycles → `interrupt[11]`=1 3 cycles after the rise and stays high. Write STATUS=1 → 0. A STATUS=1 write coinciding with a new rise leaves it 1.
- `ext_irq_i` rise while `ext_ie`=0 → no pending. Assert `reset` while both requests are active → `interrupt`=0 the next cycle.

Source files
------------

// File: rtl/timer_intr_ctrl.sv
`timescale 1ns/1ps
// timer_intr_ctrl: memory-mapped machine timer (64-bit mtime/mtimecmp) and
// external-interrupt front end that drives the CSR interrupt vector.
// Ports: clk/reset (sync, active-high); addr/wdata/wr_en/rd_en bus slave
//   with combinational rdata; ext_irq_i async line; interrupt[7]=timer,
//   interrupt[11]=external.
// Latency: reads are combinational. Writes land at the clock edge.
//   Timer request is one cycle behind the compare. External request is
//   three edges after the line is first sampled.
// Backpressure: none; every bus access completes in its own cycle.
module timer_intr_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        ext_irq_i,
  output logic [31:0] rdata,
  output logic [31:0] interrupt
);

  localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  localparam logic [7:0] OFF_MTIME_LO = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI = 8'h04;
  localparam logic [7:0] OFF_CMP_LO   = 8'h08;
  localparam logic [7:0] OFF_CMP_HI   = 8'h0C;
  localparam logic [7:0] OFF_CTRL     = 8'h10;
  localparam logic [7:0] OFF_STATUS   = 8'h14;

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [31:0]   hi_shadow_q, hi_shadow_d;
  logic          cnt_en_q, cnt_en_d;
  logic          tmr_ie_q, tmr_ie_d;
  logic          ext_ie_q, ext_ie_d;
  logic          tmr_irq_q, tmr_irq_d;
  logic          ext_pend_q, ext_pend_d;
  logic          s1_q, s2_q, s3_q;
  logic          rise_q, rise_d;

  logic       hit;
  logic       wr_hit, rd_hit;
  logic [7:0] off;

  assign hit    = (addr[31:8] == BASE_ADDR[31:8]);
  assign off    = addr[7:0];
  assign wr_hit = wr_en & hit;
  assign rd_hit = rd_en & hit;

  // Edge of the synchronised line, registered once more so the pending bit
  // lands three edges after the line is first sampled by s1.
  assign rise_d = s2_q & ~s3_q;

  always_comb begin
    mtime_d     = mtime_q;
    pcnt_d      = pcnt_q;
    mtimecmp_d  = mtimecmp_q;
    hi_shadow_d = hi_shadow_q;
    cnt_en_d    = cnt_en_q;
    tmr_ie_d    = tmr_ie_q;
    ext_ie_d    = ext_ie_q;
    ext_pend_d  = ext_pend_q;

    // A write to either mtime half wins over the tick and restarts the
    // prescaler so the new value gets a full period before incrementing.
    if (wr_hit && off == OFF_MTIME_LO) begin
      mtime_d[31:0] = wdata;
      pcnt_d        = '0;
    end else if (wr_hit && off == OFF_MTIME_HI) begin
      mtime_d[63:32] = wdata;
      pcnt_d         = '0;
    end else if (cnt_en_q) begin
      if (pcnt_q == PMAX) begin
        pcnt_d  = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end

    if (wr_hit && off == OFF_CMP_LO) mtimecmp_d[31:0]  = wdata;
    if (wr_hit && off == OFF_CMP_HI) mtimecmp_d[63:32] = wdata;

    if (wr_hit && off == OFF_CTRL) begin
      cnt_en_d = wdata[0];
      tmr_ie_d = wdata[1];
      ext_ie_d = wdata[2];
    end

    // Reading the low word freezes the matching high word for a later read.
    if (rd_hit && off == OFF_MTIME_LO) hi_shadow_d = mtime_q[63:32];

    // Set has priority over a write-one-to-clear in the same cycle.
    if (rise_q && ext_ie_q)                          ext_pend_d = 1'b1;
    else if (wr_hit && off == OFF_STATUS && wdata[0]) ext_pend_d = 1'b0;
  end

  assign tmr_irq_d = tmr_ie_q && (mtime_q >= mtimecmp_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q     <= '0;
      pcnt_q      <= '0;
      mtimecmp_q  <= '1;
      hi_shadow_q <= '0;
      cnt_en_q    <= 1'b0;
      tmr_ie_q    <= 1'b0;
      ext_ie_q    <= 1'b0;
      tmr_irq_q   <= 1'b0;
      ext_pend_q  <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      pcnt_q      <= pcnt_d;
      mtimecmp_q  <= mtimecmp_d;
      hi_shadow_q <= hi_shadow_d;
      cnt_en_q    <= cnt_en_d;
      tmr_ie_q    <= tmr_ie_d;
      ext_ie_q    <= ext_ie_d;
      tmr_irq_q   <= tmr_irq_d;
      ext_pend_q  <= ext_pend_d;
      s1_q        <= ext_irq_i;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      rise_q      <= rise_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      case (off)
        OFF_MTIME_LO: rdata = mtime_q[31:0];
        OFF_MTIME_HI: rdata = hi_shadow_q;
        OFF_CMP_LO:   rdata = mtimecmp_q[31:0];
        OFF_CMP_HI:   rdata = mtimecmp_q[63:32];
        OFF_CTRL:     rdata = {29'd0, ext_ie_q, tmr_ie_q, cnt_en_q};
        OFF_STATUS:   rdata = {29'd0, s2_q, tmr_irq_q, ext_pend_q};
        default:      rdata = '0;
      endcase
    end
  end

  always_comb begin
    interrupt     = '0;
    interrupt[7]  = tmr_irq_q;
    interrupt[11] = ext_pend_q;
  end

endmodule

// File: tb/tb_timer_intr_ctrl.sv
`timescale 1ns/1ps
// Directed bench for timer_intr_ctrl: two instances (PRESCALE 4 and 1)
// share one bus; each test looks only at the instance it targets.
module tb_timer_intr_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_MLO = BASE + 32'h00;
  localparam logic [31:0] A_MHI = BASE + 32'h04;
  localparam logic [31:0] A_CLO = BASE + 32'h08;
  localparam logic [31:0] A_CHI = BASE + 32'h0C;
  localparam logic [31:0] A_CTL = BASE + 32'h10;
  localparam logic [31:0] A_STS = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        ext_irq = 1'b0;
  logic [31:0] rdata4, rdata1, intr4, intr1;

  int n_checks = 0;
  int n_fail   = 0;

  timer_intr_ctrl #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wr_en(wr_en),
    .rd_en(rd_en), .ext_irq_i(ext_irq), .rdata(rdata4), .interrupt(intr4)
  );

  timer_intr_ctrl #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wr_en(wr_en),
    .rd_en(rd_en), .ext_irq_i(ext_irq), .rdata(rdata1), .interrupt(intr1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d4, output logic [31:0] d1);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    #1;
    d4 = rdata4; d1 = rdata1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r4, r1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_intr4", intr4, 32'h0);
    check_eq("rst_intr1", intr1, 32'h0);
    bus_read(A_CLO, r4, r1); check_eq("rst_cmp_lo", r4, 32'hFFFF_FFFF);
    bus_read(A_CHI, r4, r1); check_eq("rst_cmp_hi", r4, 32'hFFFF_FFFF);
    bus_read(A_MLO, r4, r1); check_eq("rst_mtime_lo", r4, 32'h0);
    bus_read(A_MHI, r4, r1); check_eq("rst_mtime_hi", r4, 32'h0);
    bus_read(A_STS, r4, r1); check_eq("rst_status", r4, 32'h0);
    bus_read(BASE + 32'h18, r4, r1); check_eq("unmapped_rd", r4, 32'h0);
    bus_read(32'h4000_0000, r4, r1); check_eq("miss_rd", r4, 32'h0);

    // Prescaled counting: 40 cycles at /4 gives 10, then freeze
    bus_write(A_CTL, 32'h1);
    bus_read(A_CTL, r4, r1); check_eq("ctrl_rb", r4, 32'h1);
    do_reset();
    bus_write(A_CTL, 32'h1);
    repeat (40) @(posedge clk);
    bus_read(A_MLO, r4, r1); check_eq("count_40", r4, 32'd10);
    bus_write(A_CTL, 32'h0);
    repeat (20) @(posedge clk);
    bus_read(A_MLO, r4, r1); check_eq("count_frozen", r4, 32'd10);

    // Timer request: mtime reaches 5 at edge C+20, irq after C+21
    do_reset();
    bus_write(A_CHI, 32'h0);
    bus_write(A_CLO, 32'd5);
    bus_write(A_CTL, 32'h3);
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      if (k == 19) check_eq("tmr_before", {31'd0, intr4[7]}, 32'h0);
      if (k == 20) check_eq("tmr_at_match", {31'd0, intr4[7]}, 32'h0);
      if (k == 21) check_eq("tmr_rise", {31'd0, intr4[7]}, 32'h1);
    end
    bus_write(A_CLO, 32'd100);
    check_eq("tmr_hold_wr_edge", {31'd0, intr4[7]}, 32'h1);
    @(posedge clk); #1;
    check_eq("tmr_clear", {31'd0, intr4[7]}, 32'h0);

    // Low word carry into high word, PRESCALE=1 instance
    do_reset();
    bus_write(A_MHI, 32'h0);
    bus_write(A_MLO, 32'hFFFF_FFFF);
    bus_read(A_MHI, r4, r1); check_eq("shadow_before_lo", r1, 32'h0);
    bus_write(A_CTL, 32'h1);
    bus_write(A_CTL, 32'h0);
    bus_read(A_MLO, r4, r1); check_eq("carry_lo", r1, 32'h0);
    bus_read(A_MHI, r4, r1); check_eq("carry_hi", r1, 32'h1);
    // Full 64-bit wrap
    bus_write(A_MHI, 32'hFFFF_FFFF);
    bus_write(A_MLO, 32'hFFFF_FFFF);
    bus_read(A_MLO, r4, r1); check_eq("allones_lo", r1, 32'hFFFF_FFFF);
    bus_read(A_MHI, r4, r1); check_eq("allones_hi", r1, 32'hFFFF_FFFF);
    bus_write(A_CTL, 32'h1);
    bus_write(A_CTL, 32'h0);
    bus_read(A_MLO, r4, r1); check_eq("wrap_lo", r1, 32'h0);
    bus_read(A_MHI, r4, r1); check_eq("wrap_hi", r1, 32'h0);

    // External request latency and hold
    do_reset();
    bus_write(A_CTL, 32'h4);
    @(negedge clk) ext_irq = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; check_eq("ext_e2", {31'd0, intr4[11]}, 32'h0);
    @(posedge clk); #1; check_eq("ext_e3", {31'd0, intr4[11]}, 32'h1);
    @(posedge clk);
    @(negedge clk) ext_irq = 1'b0;
    repeat (4) @(posedge clk); #1;
    check_eq("ext_stays", {31'd0, intr4[11]}, 32'h1);
    bus_write(A_STS, 32'h1);
    check_eq("ext_w1c", {31'd0, intr4[11]}, 32'h0);
    // Clear coinciding with a new rise: set wins
    repeat (4) @(posedge clk);
    @(negedge clk) ext_irq = 1'b1;
    repeat (3) @(posedge clk);
    bus_write(A_STS, 32'h1);
    check_eq("ext_set_wins", {31'd0, intr4[11]}, 32'h1);
    // Held level does not re-set after a clear
    bus_write(A_STS, 32'h1);
    check_eq("ext_clr2", {31'd0, intr4[11]}, 32'h0);
    repeat (6) @(posedge clk); #1;
    check_eq("ext_no_reset_lvl", {31'd0, intr4[11]}, 32'h0);
    bus_read(A_STS, r4, r1); check_eq("status_raw", r4, 32'h4);
    @(negedge clk) ext_irq = 1'b0;

    // Rise with ext_ie=0 leaves nothing pending
    bus_write(A_CTL, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk) ext_irq = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) ext_irq = 1'b0;
    repeat (6) @(posedge clk); #1;
    check_eq("ext_masked", {31'd0, intr4[11]}, 32'h0);
    bus_read(A_STS, r4, r1); check_eq("ext_masked_sts", r4, 32'h0);

    // Reset with both requests active
    bus_write(A_CHI, 32'h0);
    bus_write(A_CLO, 32'h0);
    bus_write(A_CTL, 32'h7);
    @(negedge clk) ext_irq = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) ext_irq = 1'b0;
    @(posedge clk); #1;
    check_eq("both_active", intr4, 32'h0000_0880);
    do_reset();
    check_eq("reset_clears_intr", intr4, 32'h0);
    bus_read(A_CTL, r4, r1); check_eq("reset_clears_ctrl", r4, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
